// File: rtl/simple_out_capture_if.sv
// simple_out_capture_if: valid/ready word stream from the capture FIFO to its consumer
interface simple_out_capture_if #(
    parameter int PACK_W = 8
);
    logic [PACK_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    modport master (output word_data, word_valid, input word_ready);
    modport slave  (input word_data, word_valid, output word_ready);
endinterface

// File: rtl/simple_out_capture.sv
// simple_out_capture: packs sampled 'out' bits LSB-first into words and buffers them in a FIFO
module simple_out_capture #(
    parameter int PACK_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                        tau2015_clk,
    input  logic                        tau2015_rst_n,
    input  logic                        clear,
    input  logic                        en,
    input  logic                        out_in,
    simple_out_capture_if.master        wo,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]            drop_cnt
);
    localparam int BC_W  = $clog2(PACK_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(PACK_W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [PACK_W-1:0] pack_q, pack_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PACK_W-1:0] mem_q [FIFO_DEPTH];
    logic [PACK_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [PACK_W-1:0] word;
    logic              sample, complete, full, pop, push, drop;

    // Per-edge decisions; clear overrides sampling and popping
    always_comb begin
        sample   = en && !clear;
        complete = sample && (bit_cnt_q == BC_LAST);
        full     = (level_q == LVL_FULL);
        pop      = !clear && wo.word_valid && wo.word_ready;
        push     = complete && (!full || pop);
        drop     = complete && full && !pop;
    end

    // Packing register: current sample lands at bit[bit_cnt]; a completed word restarts empty
    always_comb begin
        word            = pack_q;
        word[bit_cnt_q] = out_in;
        pack_d          = (clear || complete) ? '0 : (sample ? word : pack_q);
        bit_cnt_d       = (clear || complete) ? '0 : (sample ? bit_cnt_q + 1'b1 : bit_cnt_q);
    end

    // FIFO storage, pointers, level counter and saturating drop counter
    always_comb begin
        mem_d = mem_q;
        if (push)
            mem_d[wr_ptr_q] = word;
        if (clear)
            mem_d = '{default: '0};
        wr_ptr_d = clear ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d = clear ? '0 : rd_ptr_q + PTR_W'(pop);
        level_d  = clear ? '0 : level_q + LVL_W'(push) - LVL_W'(pop);
        drop_d   = clear ? '0 : drop_q + CNT_W'(drop && (drop_q != '1));
    end

    assign wo.word_valid = (level_q != '0);
    assign wo.word_data  = wo.word_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level    = level_q;
    assign drop_cnt      = drop_q;

    // State registers with asynchronous reset
    always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
        if (!tau2015_rst_n) begin
            pack_q    <= '0;
            bit_cnt_q <= '0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            drop_q    <= '0;
        end else begin
            pack_q    <= pack_d;
            bit_cnt_q <= bit_cnt_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            drop_q    <= drop_d;
        end
    end
endmodule

// File: tb/tb_simple_out_capture.sv
// tb_simple_out_capture: directed and random stimulus against a queue-based reference model
module tb_simple_out_capture;
    localparam int PACK_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;
    localparam int DROP_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n, clear, en, out_in;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic [CNT_W-1:0] drop_cnt;
    simple_out_capture_if #(.PACK_W(PACK_W)) bus ();

    simple_out_capture #(.PACK_W(PACK_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .tau2015_clk  (clk),
        .tau2015_rst_n(rst_n),
        .clear        (clear),
        .en           (en),
        .out_in       (out_in),
        .wo           (bus),
        .fifo_level   (fifo_level),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit           m_bits[$];
    logic [7:0]   m_fifo[$];
    int           m_drop = 0;
    logic [7:0]   held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_fifo.delete();
        m_drop = 0;
    endtask

    task automatic model_edge(input logic e, input logic b, input logic r, input logic c);
        logic [7:0] w;
        if (c) begin
            model_reset();
        end else begin
            if (m_fifo.size() > 0 && r)
                void'(m_fifo.pop_front());
            if (e) begin
                m_bits.push_back(b);
                if (m_bits.size() == PACK_W) begin
                    w = '0;
                    for (int i = 0; i < PACK_W; i++)
                        w[i] = m_bits[i];
                    m_bits.delete();
                    if (m_fifo.size() < FIFO_DEPTH)
                        m_fifo.push_back(w);
                    else if (m_drop < DROP_MAX)
                        m_drop++;
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, " valid"}, 32'(bus.word_valid), 32'(m_fifo.size() > 0));
        chk({tag, " data"}, 32'(bus.word_data), (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'd0);
        chk({tag, " level"}, 32'(fifo_level), 32'(m_fifo.size()));
        chk({tag, " drop"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic step(input logic e, input logic b, input logic r, input logic c, input string tag);
        en = e;
        out_in = b;
        bus.word_ready = r;
        clear = c;
        @(posedge clk);
        model_edge(e, b, r, c);
        #1;
        compare(tag);
    endtask

    task automatic feed_word(input logic [7:0] w, input logic last_ready, input string tag);
        for (int i = 0; i < PACK_W; i++)
            step(1'b1, w[i], (i == PACK_W - 1) ? last_ready : 1'b0, 1'b0, tag);
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] exp_heads[4];
        rst_n = 1'b0;
        clear = 1'b0;
        en = 1'b0;
        out_in = 1'b0;
        bus.word_ready = 1'b0;
        #12;
        compare("reset");
        @(negedge clk);
        rst_n = 1'b1;

        pat = 8'h4D;
        for (int i = 0; i < PACK_W; i++) begin
            step(1'b1, pat[i], 1'b0, 1'b0, "pack");
            if (i == PACK_W - 2)
                chk("pack not yet valid", 32'(bus.word_valid), 32'd0);
        end
        chk("pack 4D data", 32'(bus.word_data), 32'h4D);
        chk("pack 4D level", 32'(fifo_level), 32'd1);

        feed_word(8'($urandom), 1'b0, "fill");
        feed_word(8'($urandom), 1'b0, "fill");
        step(1'b1, 1'b1, 1'b0, 1'b0, "partial");
        chk("pre-reset level 3", 32'(fifo_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async reset valid", 32'(bus.word_valid), 32'd0);
        chk("async reset data", 32'(bus.word_data), 32'd0);
        chk("async reset level", 32'(fifo_level), 32'd0);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++)
            feed_word(8'hFF, 1'b0, "overflow");
        chk("overflow level", 32'(fifo_level), 32'd4);
        chk("overflow head", 32'(bus.word_data), 32'hFF);
        chk("overflow drop", 32'(drop_cnt), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("overflow each head FF", 32'(bus.word_data), 32'hFF);
            step(1'b0, 1'b0, 1'b1, 1'b0, "overflow drain");
        end

        step(1'b0, 1'b0, 1'b0, 1'b1, "clear");
        feed_word(8'h11, 1'b0, "fullpop");
        feed_word(8'h22, 1'b0, "fullpop");
        feed_word(8'h33, 1'b0, "fullpop");
        feed_word(8'h44, 1'b0, "fullpop");
        feed_word(8'hA5, 1'b1, "fullpop");
        chk("fullpop level", 32'(fifo_level), 32'd4);
        chk("fullpop drop", 32'(drop_cnt), 32'd0);
        exp_heads = '{8'h22, 8'h33, 8'h44, 8'hA5};
        for (int k = 0; k < 4; k++) begin
            chk("fullpop order", 32'(bus.word_data), 32'(exp_heads[k]));
            step(1'b0, 1'b0, 1'b1, 1'b0, "fullpop drain");
        end

        for (int i = 0; i < 16; i++)
            step((i % 2) == 0, 1'($urandom), 1'b0, 1'b0, "gaps");
        chk("gaps one word", 32'(fifo_level), 32'd1);
        held = bus.word_data;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom), 1'b0, 1'b0, "hold");
            chk("hold stable", 32'(bus.word_data), 32'(held));
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, "gaps pop");

        feed_word(8'h5A, 1'b0, "preclear");
        for (int i = 0; i < PACK_W - 1; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, "preclear partial");
        step(1'b1, 1'b1, 1'b1, 1'b1, "clear on complete");
        chk("clear level", 32'(fifo_level), 32'd0);
        chk("clear drop", 32'(drop_cnt), 32'd0);
        feed_word(8'h3C, 1'b0, "fresh");
        chk("fresh word", 32'(bus.word_data), 32'h3C);
        chk("fresh level", 32'(fifo_level), 32'd1);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 59) == 0), "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
